// File: rtl/secure_memory_access_pkg.sv
// Shared definitions for the scrambled-memory custom instruction: op codes,
// FSM state encoding, default key and wait-counter width.
package secure_memory_access_pkg;

    localparam logic [31:0] DEFAULT_KEY = 32'h95DA4EAB;
    localparam int          WAIT_CNT_W  = 16;

    localparam logic [2:0] OP_READ  = 3'd0;
    localparam logic [2:0] OP_WRITE = 3'd1;
    localparam logic [2:0] OP_RMW   = 3'd2;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_XF   = 3'd2,
        S_WR   = 3'd3,
        S_FIN  = 3'd4
    } state_e;

    function automatic logic [31:0] scramble(input logic [31:0] w, input logic [31:0] key);
        return w ^ key;
    endfunction

endpackage

// File: rtl/secure_memory_bus_if.sv
// Avalon-MM strobe generation and waitrequest handshake for one bus phase.
// SECMEM_TIMEOUT_EN adds a stall counter that aborts a phase after TIMEOUT_CYCLES.
module secure_memory_bus_if
    import secure_memory_access_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic clk_en_i,
    input  logic rd_req_i,
    input  logic wr_req_i,
    input  logic waitrequest_i,
    output logic chipselect_o,
    output logic read_o,
    output logic write_o,
    output logic phase_done_o,
    output logic phase_timeout_o
);

    logic active;

    // Requests come straight from the FSM state register, so strobes only move on clock edges.
    assign read_o       = rd_req_i;
    assign write_o      = wr_req_i;
    assign active       = rd_req_i | wr_req_i;
    assign chipselect_o = active;
    assign phase_done_o = active & ~waitrequest_i;

`ifdef SECMEM_TIMEOUT_EN
    logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!active)
            cnt_d = '0;
        else if (waitrequest_i)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i)
            cnt_q <= '0;
        else if (clk_en_i)
            cnt_q <= cnt_d;
    end

    // Fires on the TIMEOUT_CYCLES-th consecutive stall cycle of the phase.
    assign phase_timeout_o = active & waitrequest_i &
                             (cnt_q == WAIT_CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic [WAIT_CNT_W+2:0] unused_sig;
    assign unused_sig      = {clk_i, reset_i, clk_en_i, WAIT_CNT_W'(TIMEOUT_CYCLES)};
    assign phase_timeout_o = 1'b0;
`endif

endmodule

// File: rtl/secure_memory_access.sv
// Nios II multi-cycle custom instruction driving an Avalon-MM master for
// XOR-scrambled READ / WRITE / RMW. Optional bus timeout: SECMEM_TIMEOUT_EN.
module secure_memory_access
    import secure_memory_access_pkg::*;
#(
    parameter logic [31:0] XOR_KEY        = DEFAULT_KEY,
    parameter int          TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_en,
    input  logic        start,
    input  logic [2:0]  n,
    input  logic [31:0] dataa,
    input  logic [31:0] datab,
    output logic        done,
    output logic [31:0] result,
    output logic        timeout,
    output logic [31:0] address,
    output logic        chipselect,
    output logic        read,
    output logic        write,
    output logic [3:0]  byteenable,
    output logic [31:0] writedata,
    input  logic [31:0] readdata,
    input  logic        waitrequest
);

    state_e      state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] src_q, src_d;
    logic [31:0] data_q, data_d;
    logic [31:0] result_q, result_d;
    logic [31:0] addr_q, addr_d;
    logic        to_q, to_d;
    logic        phase_done, phase_timeout;
    logic [2:0]  unused_bits;

    secure_memory_bus_if #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_bus_if (
        .clk_i           (clk),
        .reset_i         (reset),
        .clk_en_i        (clk_en),
        .rd_req_i        (state_q == S_RD),
        .wr_req_i        (state_q == S_WR),
        .waitrequest_i   (waitrequest),
        .chipselect_o    (chipselect),
        .read_o          (read),
        .write_o         (write),
        .phase_done_o    (phase_done),
        .phase_timeout_o (phase_timeout)
    );

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        src_d    = src_q;
        data_d   = data_q;
        result_d = result_q;
        addr_d   = addr_q;
        to_d     = to_q;
        case (state_q)
            S_IDLE: if (start) begin
                addr_d = {dataa[31:2], 2'b00};
                op_d   = n;
                to_d   = 1'b0;
                case (n)
                    OP_READ, OP_RMW: state_d = S_RD;
                    OP_WRITE: begin
                        src_d   = datab;
                        state_d = S_XF;
                    end
                    default: begin
                        result_d = '0;
                        state_d  = S_FIN;
                    end
                endcase
            end
            S_RD: begin
                if (phase_timeout) begin
                    result_d = '1;
                    to_d     = 1'b1;
                    state_d  = S_FIN;
                end else if (phase_done) begin
                    src_d   = readdata;
                    state_d = S_XF;
                end
            end
            // For RMW the descrambled word is both the result and what gets written back.
            S_XF: begin
                data_d = scramble(src_q, XOR_KEY);
                if (op_q == OP_READ) begin
                    result_d = scramble(src_q, XOR_KEY);
                    state_d  = S_FIN;
                end else begin
                    state_d = S_WR;
                end
            end
            S_WR: begin
                if (phase_timeout) begin
                    result_d = '1;
                    to_d     = 1'b1;
                    state_d  = S_FIN;
                end else if (phase_done) begin
                    result_d = data_q;
                    state_d  = S_FIN;
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            src_q    <= '0;
            data_q   <= '0;
            result_q <= '0;
            addr_q   <= '0;
            to_q     <= 1'b0;
        end else if (clk_en) begin
            state_q  <= state_d;
            op_q     <= op_d;
            src_q    <= src_d;
            data_q   <= data_d;
            result_q <= result_d;
            addr_q   <= addr_d;
            to_q     <= to_d;
        end
    end

    assign done       = (state_q == S_FIN);
    assign result     = result_q;
    assign address    = addr_q;
    assign writedata  = data_q;
    assign byteenable = 4'b1111;

`ifdef SECMEM_TIMEOUT_EN
    assign timeout     = done & to_q;
    assign unused_bits = {dataa[1:0], 1'b0};
`else
    assign timeout     = 1'b0;
    assign unused_bits = {dataa[1:0], to_q};
`endif

endmodule

// File: tb/tb_secure_memory_access.sv
// Self-checking bench for secure_memory_access: Avalon slave model with
// programmable stalls, vector table plus scoreboard, and hand-written corner cases.
module tb_secure_memory_access;

    logic        clk = 1'b0;
    logic        reset, clk_en, start;
    logic [2:0]  n;
    logic [31:0] dataa, datab;
    logic        done, timeout, chipselect, read, write;
    logic [31:0] result, address, writedata, readdata;
    logic [3:0]  byteenable;
    logic        waitrequest;

`ifdef SECMEM_TIMEOUT_EN
    localparam int TO_CYC = 8;
`else
    localparam int TO_CYC = 256;
`endif

    secure_memory_access #(.TIMEOUT_CYCLES(TO_CYC)) dut (
        .clk(clk), .reset(reset), .clk_en(clk_en), .start(start), .n(n),
        .dataa(dataa), .datab(datab), .done(done), .result(result),
        .timeout(timeout), .address(address), .chipselect(chipselect),
        .read(read), .write(write), .byteenable(byteenable),
        .writedata(writedata), .readdata(readdata), .waitrequest(waitrequest)
    );

    always #5 clk = ~clk;

    // Avalon slave model
    bit [31:0] mem [256];
    int        stall_cfg = 0, stall_cnt = 0;
    int        rd_cyc_tot = 0, wr_n_tot = 0, cyc = 0;
    bit        rw_both = 0, cs_bad = 0;
    bit        pre_en = 0;
    logic [7:0]  pre_idx = '0;
    logic [31:0] pre_val = '0;

    assign readdata    = mem[address[9:2]];
    assign waitrequest = (read | write) && (stall_cnt < stall_cfg);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (pre_en) mem[pre_idx] <= pre_val;
        if (read) rd_cyc_tot <= rd_cyc_tot + 1;
        if (write && !waitrequest) begin
            mem[address[9:2]] <= writedata;
            wr_n_tot <= wr_n_tot + 1;
        end
        if (read && write) rw_both <= 1'b1;
        if (chipselect !== (read | write)) cs_bad <= 1'b1;
        if ((read || write) && waitrequest) stall_cnt <= stall_cnt + 1;
        else stall_cnt <= 0;
    end

    // Scoreboard
    typedef struct {
        logic [31:0] res;
        logic        to;
        int          lat;
        int          start_cyc;
        logic [31:0] addr;
        int          rd_base;
        int          wr_base;
        int          rd_cyc;
        int          wr_n;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [2:0]  n;
        logic [31:0] dataa, datab;
        bit          pre;
        logic [31:0] pre_val;
        int          stalls;
        logic [31:0] res;
        logic        to;
        int          lat;
        int          rd_cyc;
        int          wr_n;
        logic [31:0] addr;
        bit          chk;
        logic [31:0] mem_val;
    } vec_t;
    vec_t vt[8];

    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] v);
        pre_en = 1; pre_idx = a[9:2]; pre_val = v;
        tick();
        pre_en = 0;
    endtask

    task automatic push(input logic [31:0] res, input logic to, input int lat,
                        input logic [31:0] addr, input int rdc, input int wrn);
        exp_t e;
        e.res = res; e.to = to; e.lat = lat; e.start_cyc = cyc; e.addr = addr;
        e.rd_base = rd_cyc_tot; e.wr_base = wr_n_tot; e.rd_cyc = rdc; e.wr_n = wrn;
        sb.push_back(e);
    endtask

    task automatic wait_done(input string tag, input int max);
        bit   got = 0;
        exp_t e;
        for (int i = 0; i < max && !got; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1;
                if (sb.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL %s: unexpected done with empty scoreboard", tag);
                end else begin
                    e = sb.pop_front();
                    chk({tag, " result"},  result, e.res);
                    chk({tag, " timeout"}, {31'd0, timeout}, {31'd0, e.to});
                    chk({tag, " latency"}, 32'(cyc - e.start_cyc), 32'(e.lat));
                    chk({tag, " address"}, address, e.addr);
                    chk({tag, " read cycles"}, 32'(rd_cyc_tot - e.rd_base), 32'(e.rd_cyc));
                    chk({tag, " writes"}, 32'(wr_n_tot - e.wr_base), 32'(e.wr_n));
                end
            end
        end
        if (!got) begin
            n_cmp++; n_bad++;
            $display("FAIL %s: no done within %0d cycles", tag, max);
            sb.delete();
        end
    endtask

    task automatic run_vec(input int k);
        vec_t  v;
        string tag;
        v   = vt[k];
        tag = $sformatf("vec%0d", k);
        if (v.pre) preload(v.addr, v.pre_val);
        stall_cfg = v.stalls;
        n = v.n; dataa = v.dataa; datab = v.datab; start = 1;
        push(v.res, v.to, v.lat, v.addr, v.rd_cyc, v.wr_n);
        tick();
        start = 0;
        wait_done(tag, 40);
        if (v.chk) chk({tag, " mem"}, mem[v.addr[9:2]], v.mem_val);
        tick();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int wr0;
        //        n     dataa         datab         pre val            st  result        to lat rd wr addr          chk mem
        vt[0] = '{3'd0, 32'h00000103, 32'h0,        1, 32'h87EE18D3, 0, 32'h12345678, 0, 3, 1, 0, 32'h00000100, 0, 32'h0};
        vt[1] = '{3'd1, 32'h00000200, 32'h0,        0, 32'h0,        0, 32'h95DA4EAB, 0, 3, 0, 1, 32'h00000200, 1, 32'h95DA4EAB};
        vt[2] = '{3'd2, 32'h00000040, 32'h0,        1, 32'h12345678, 0, 32'h87EE18D3, 0, 4, 1, 1, 32'h00000040, 1, 32'h87EE18D3};
        vt[3] = '{3'd3, 32'h00000301, 32'h11111111, 0, 32'h0,        0, 32'h00000000, 0, 1, 0, 0, 32'h00000300, 0, 32'h0};
        vt[4] = '{3'd0, 32'h00000104, 32'h0,        1, 32'h95DA4EAB, 5, 32'h00000000, 0, 8, 6, 0, 32'h00000104, 0, 32'h0};
        vt[5] = '{3'd1, 32'h000002FE, 32'hFFFFFFFF, 0, 32'h0,        2, 32'h6A25B154, 0, 5, 0, 1, 32'h000002FC, 1, 32'h6A25B154};
        vt[6] = '{3'd7, 32'h00000000, 32'h0,        0, 32'h0,        0, 32'h00000000, 0, 1, 0, 0, 32'h00000000, 0, 32'h0};
        vt[7] = '{3'd2, 32'h000003FC, 32'h0,        1, 32'hDEADBEEF, 1, 32'h4B77F044, 0, 6, 2, 1, 32'h000003FC, 1, 32'h4B77F044};

        reset = 1; clk_en = 1; start = 0; n = '0; dataa = '0; datab = '0;
        tick(); tick();
        chk("rst done", {31'd0, done}, 32'd0);
        chk("rst timeout", {31'd0, timeout}, 32'd0);
        chk("rst chipselect", {31'd0, chipselect}, 32'd0);
        chk("rst read", {31'd0, read}, 32'd0);
        chk("rst write", {31'd0, write}, 32'd0);
        chk("rst result", result, 32'h0);
        chk("rst address", address, 32'h0);
        chk("rst writedata", writedata, 32'h0);
        chk("byteenable", {28'd0, byteenable}, 32'hF);
        reset = 0;
        tick();

        for (int k = 0; k < 8; k++) run_vec(k);

        // Reset asserted mid write phase: strobes must drop before the next edge.
        stall_cfg = 3; wr0 = wr_n_tot;
        n = 3'd1; dataa = 32'h80; datab = 32'h1; start = 1;
        tick(); start = 0;
        tick();
        chk("rstWR write before reset", {31'd0, write}, 32'd1);
        #2 reset = 1;
        #1;
        chk("rstWR write", {31'd0, write}, 32'd0);
        chk("rstWR chipselect", {31'd0, chipselect}, 32'd0);
        chk("rstWR done", {31'd0, done}, 32'd0);
        chk("rstWR result", result, 32'h0);
        @(posedge clk); #1 reset = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rstWR no done", {31'd0, done}, 32'd0);
        end
        chk("rstWR no write", 32'(wr_n_tot - wr0), 32'd0);
        chk("rstWR mem", mem[32], 32'h0);
        tick();

        // Start held high while busy: only the first op runs.
        preload(32'h10, 32'h5F24BEA6);
        stall_cfg = 3;
        n = 3'd0; dataa = 32'h10; start = 1;
        push(32'hCAFEF00D, 1'b0, 6, 32'h10, 4, 0);
        tick();
        n = 3'd1;
        tick(); tick(); tick();
        start = 0;
        wait_done("busy", 40);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("busy no 2nd done", {31'd0, done}, 32'd0);
        end
        chk("busy no extra bus", {31'd0, chipselect}, 32'd0);
        tick();

        // clk_en low freezes the FSM in RD while the read strobe stays up.
        preload(32'h20, 32'h87EE18D3);
        stall_cfg = 0;
        n = 3'd0; dataa = 32'h20; start = 1;
        push(32'h12345678, 1'b0, 6, 32'h20, 4, 0);
        tick();
        start = 0; clk_en = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("freeze read held", {31'd0, read}, 32'd1);
            chk("freeze no done", {31'd0, done}, 32'd0);
            tick();
        end
        clk_en = 1;
        wait_done("freeze", 20);
        tick();

`ifdef SECMEM_TIMEOUT_EN
        stall_cfg = 1000;
        n = 3'd0; dataa = 32'h30; start = 1;
        push(32'hFFFFFFFF, 1'b1, TO_CYC + 1, 32'h30, TO_CYC, 0);
        tick(); start = 0;
        wait_done("to_read", 40);
        tick();
        n = 3'd2; dataa = 32'h34; start = 1;
        push(32'hFFFFFFFF, 1'b1, TO_CYC + 1, 32'h34, TO_CYC, 0);
        tick(); start = 0;
        wait_done("to_rmw", 40);
        chk("to_rmw strobes low", {30'd0, read, write}, 32'd0);
        stall_cfg = 0;
        tick();
`endif

        chk("never read and write together", {31'd0, rw_both}, 32'd0);
        chk("chipselect tracks strobes", {31'd0, cs_bad}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
